// File: rtl/bshift_reg_uni.sv
// bshift_reg_uni: universal serial shift register for the serial boundary.
// Deserialises MSB-first (left) or LSB-first (right) bit streams into words,
// serialises parallel-loaded words out via o_sbit, and pulses o_word_valid
// once every WIDTH enabled shifts.
//
// Optional feature macro: BSHIFT_REG_UNI_LOAD_EN
//   defined   -> i_load/i_data perform a parallel load (priority sclr > load > en)
//   undefined -> i_load/i_data are ignored and no load path exists (sclr > en)
module bshift_reg_uni #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             i_sclr,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_bit,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sbit,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_word_valid
);

  // A one-bit register cannot shift a word; reject it at elaboration.
  if (WIDTH < 2) begin : g_width_check
    $error("bshift_reg_uni: WIDTH must be >= 2");
  end

  // Counter wraps explicitly at WIDTH-1, not at 2^CNT_W, so non-power-of-two
  // widths still produce one pulse per WIDTH shifts.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shift_val;
  logic [CNT_W-1:0] cnt_q;
  logic             word_done;
  logic             wv_q;

`ifndef BSHIFT_REG_UNI_LOAD_EN
  // Load ports stay on the boundary for drop-in compatibility but feed nothing.
  logic unused_load;
  assign unused_load = ^{i_load, i_data};
`endif

  // Next shifted word: left brings i_bit in at bit 0, right at bit WIDTH-1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    shift_val = data_q;
    if (i_dir) shift_val = {i_bit, data_q[WIDTH-1:1]};
    else       shift_val = {data_q[WIDTH-2:0], i_bit};
  end

  assign word_done = (cnt_q == CNT_LAST);

  // State update: priority sclr > (load) > enabled shift > hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_sclr) begin
      data_q <= '0;
      cnt_q  <= '0;
      wv_q   <= 1'b0;
    end
`ifdef BSHIFT_REG_UNI_LOAD_EN
    else if (i_load) begin
      // A load restarts the word; a pulse that would have fired here is dropped.
      data_q <= i_data;
      cnt_q  <= '0;
      wv_q   <= 1'b0;
    end
`endif
    else if (i_en) begin
      data_q <= shift_val;
      if (word_done) begin
        cnt_q <= '0;
        wv_q  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
        wv_q  <= 1'b0;
      end
    end else begin
      wv_q <= 1'b0;
    end
  end

  assign o_data       = data_q;
  assign o_cnt        = cnt_q;
  assign o_word_valid = wv_q;
  // Serial out tracks i_dir within the cycle: the bit that leaves next.
  assign o_sbit       = i_dir ? data_q[0] : data_q[WIDTH-1];

endmodule

// File: doc/bshift_reg_uni.md
# bshift_reg_uni

Parametrised universal serial shift register with enable, direction select, optional parallel load, serial output, and a word-complete pulse. It is the successor to the fixed left-shift enable register. It sits at the serial boundary of the design: it deserialises incoming bits (MSB-first or LSB-first) into words and serialises loaded words out. A one-cycle pulse marks every WIDTH enabled shifts.

## Interface

- WIDTH, 4, register width in bits; legal range WIDTH >= 2
- CNT_W, $clog2(WIDTH), localparam; width of the bit counter
- clk  input  1  clock; all state updates on the rising edge
- i_sclr  input  1  reset; synchronous, active-high
- i_en  input  1  shift enable; one shift per enabled edge
- i_dir  input  1  direction: 0 = left (bits enter at bit 0, MSB-first word), 1 = right (bits enter at bit WIDTH-1, LSB-first word)
- i_bit  input  1  serial input bit
- i_load  input  1  parallel load strobe (active only with the macro below)
- i_data  input  WIDTH  parallel load value
- o_data  output  WIDTH  register contents
- o_sbit  output  1  serial output; combinational: i_dir=0 -> o_data[WIDTH-1], i_dir=1 -> o_data[0]
- o_cnt  output  CNT_W  enabled shifts since the last clear, load or word completion; range 0..WIDTH-1
- o_word_valid  output  1  registered one-cycle pulse marking word completion

## Operation

- Reset values on i_sclr: o_data = 0, o_cnt = 0, o_word_valid = 0.
- Priority per edge is i_sclr > i_load > i_en > hold.
- Load:
  - o_data <= i_data; o_cnt <= 0; o_word_valid <= 0.
  - i_en and i_bit are ignored on that edge.
- Shift left (i_en=1, i_dir=0): o_data <= {o_data[WIDTH-2:0], i_bit}.
- Shift right (i_en=1, i_dir=1): o_data <= {i_bit, o_data[WIDTH-1:1]}.
- Counter on each enabled shift:
  - If o_cnt == WIDTH-1: o_cnt <= 0 and o_word_valid <= 1.
  - Otherwise: o_cnt <= o_cnt + 1 and o_word_valid <= 0.
- Hold (no sclr, no load, i_en=0): o_data and o_cnt keep their values; o_word_valid <= 0.
- o_word_valid is therefore never high for two consecutive cycles unless shifts complete back-to-back words. WIDTH=2 with continuous enable gives a pulse every 2nd cycle.
- i_dir may change between any two shifts. The counter is unaffected; the word is whatever mix results.
- Counter arithmetic is unsigned and wraps explicitly at WIDTH-1, not at 2^CNT_W.

## Timing

- Latency: i_bit appears in o_data one edge after being sampled with i_en=1.
- o_word_valid rises on the same edge as the WIDTH-th shift. It is therefore aligned with the completed o_data and o_cnt = 0, and stays high for that one cycle only.
- o_sbit follows i_dir combinationally within the cycle; o_data does not.
- Reset mid-word discards the partial word; no o_word_valid is produced.
- Load on the edge that would have completed a word suppresses the pulse.
- Sampling convention: stimulus changes 1 time unit after the rising edge; checks are made at that same point.

## Configuration

- Macro: BSHIFT_REG_UNI_LOAD_EN.
- Defined: parallel load behaves as described above.
- Undefined:
  - i_load and i_data remain as ports but are ignored.
  - The load branch is removed; priority becomes i_sclr > i_en > hold.
  - The load branch is not synthesised.

## Test plan

WIDTH=4 for all scenarios.

- Reset: i_sclr=1 for one edge with i_en=1, i_bit=1 -> o_data=0000, o_cnt=0, o_word_valid=0.
- Left shift: i_dir=0, i_en=1, bits 1,0,1,1 on four edges -> o_data 0001, 0010, 0101, 1011; o_cnt 1, 2, 3, 0; o_word_valid=1 only after the 4th edge. Next edge with i_en=0 -> o_word_valid=0, o_data=1011.
- Right shift with gaps: from reset, i_dir=1, bits 1,1,0,1 with i_en=0 inserted after the 2nd bit -> o_data 1000, 1100, 1100 (held, o_cnt=2), 0110, 1011; o_word_valid=1 only after the final edge.
- Load and serialise (macro defined):
  - i_load=1, i_data=1010, i_en=1 -> o_data=1010, o_cnt=0.
  - o_sbit=1 with i_dir=0 and 0 with i_dir=1.
  - Then a left shift with i_bit=0 -> o_data=0100, o_sbit=0, o_cnt=1.
- Priority and mid-word reset: after 3 left shifts (o_cnt=3), drive i_sclr=1, i_load=1, i_en=1 -> o_data=0000, o_cnt=0, no o_word_valid pulse.
- Macro undefined: repeat the load scenario from o_data=0000 with i_bit=1 -> o_data=0001, o_cnt=1; i_data is ignored.
